alu_packet_fsm: RTL and testbench

Parametrised command-packet state machine between the UART receiver and UART transmitter of the UART-ALU. It parses byte-stream packets from RX, performs ECHO, ADD, MUL or XOR over little-endian operands of configurable width, and streams result bytes to TX. Malformed packets are drained without output.

---
 rtl/alu_packet_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_alu_packet_fsm.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_packet_fsm.sv
// alu_packet_fsm: command-packet engine between UART RX and UART TX.
// Parses opcode / reserved / len_lo / len_hi headers, then echoes the payload
// or folds little-endian DATA_W operands with ADD / XOR (and MUL when the
// ALU_MUL_EN macro is defined), streaming the result LSB first.
// Malformed packets raise a one-cycle err_o and have their payload drained.
module alu_packet_fsm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  localparam int unsigned       NB       = DATA_W / 8;
  localparam logic [3:0]        LAST_IDX = 4'(NB - 1);
  localparam logic [LEN_W-1:0]  NB_L     = LEN_W'(NB);
  localparam logic [LEN_W-1:0]  HDR_L    = LEN_W'(4);
  localparam logic [LEN_W-1:0]  ONE_L    = LEN_W'(1);

  localparam logic [7:0] OP_ECHO = 8'h10;
  localparam logic [7:0] OP_ADD  = 8'h20;
  localparam logic [7:0] OP_XOR  = 8'h40;
`ifdef ALU_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'h30;
`endif

  typedef enum logic [3:0] {
    S_OPCODE,
    S_RSV,
    S_LENLO,
    S_LENHI,
    S_DECIDE,
    S_OPERAND,
    S_TRANSMIT,
    S_ECHO,
    S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          opcode_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [DATA_W-1:0]   acc_q;
  logic [3:0]          byte_idx_q;
  logic                first_q;
  logic [3:0]          tx_idx_q;

  logic                rx_ready_int;
  logic                rx_fire;
  logic                len_short;
  logic [LEN_W-1:0]    p_len;
  logic                p_zero;
  logic                is_echo;
  logic                is_arith;
  logic                pkt_invalid;
  logic [DATA_W-1:0]   operand_next;
  logic [DATA_W-1:0]   combined;

  // Header decode: payload length and packet validity for the decision cycle
  always_comb begin
    len_short = (len_q < HDR_L);
    p_len     = len_q - HDR_L;
    p_zero    = len_short || (p_len == '0);
    is_echo   = (opcode_q == OP_ECHO);
    is_arith  = (opcode_q == OP_ADD) || (opcode_q == OP_XOR);
`ifdef ALU_MUL_EN
    is_arith  = is_arith || (opcode_q == OP_MUL);
`endif
    pkt_invalid = len_short || !(is_echo || is_arith) ||
                  (is_arith && (p_zero || ((p_len % NB_L) != '0)));
  end

  // Operand assembly (little-endian shift-in from the top) and ALU combine
  always_comb begin
    operand_next = (shreg_q >> 8) | (DATA_W'(rx_data_i) << (DATA_W - 8));
    combined     = acc_q;
    case (opcode_q)
      OP_ADD:  combined = acc_q + operand_next;
      OP_XOR:  combined = acc_q ^ operand_next;
`ifdef ALU_MUL_EN
      OP_MUL:  combined = acc_q * operand_next;
`endif
      default: combined = acc_q;
    endcase
  end

  // RX readiness by state; Echo hands TX backpressure straight through
  always_comb begin
    rx_ready_int = 1'b0;
    case (state_q)
      S_OPCODE, S_RSV, S_LENLO, S_LENHI, S_OPERAND, S_DRAIN: rx_ready_int = 1'b1;
      S_ECHO:  rx_ready_int = tx_ready_i;
      default: rx_ready_int = 1'b0;
    endcase
    rx_fire = rx_valid_i && rx_ready_int;
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_OPCODE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OPCODE: if (rx_fire) state_d = S_RSV;
      S_RSV:    if (rx_fire) state_d = S_LENLO;
      S_LENLO:  if (rx_fire) state_d = S_LENHI;
      S_LENHI:  if (rx_fire) state_d = S_DECIDE;
      S_DECIDE: begin
        if (pkt_invalid)  state_d = p_zero ? S_OPCODE : S_DRAIN;
        else if (is_echo) state_d = p_zero ? S_OPCODE : S_ECHO;
        else              state_d = S_OPERAND;
      end
      S_OPERAND:  if (rx_fire && cnt_q == ONE_L) state_d = S_TRANSMIT;
      S_TRANSMIT: if (tx_ready_i && tx_idx_q == LAST_IDX) state_d = S_OPCODE;
      S_ECHO:     if (rx_fire && cnt_q == ONE_L) state_d = S_OPCODE;
      S_DRAIN:    if (rx_fire && cnt_q == ONE_L) state_d = S_OPCODE;
      default:    state_d = S_OPCODE;
    endcase
  end

  // Output logic; reset forces every output to its idle value
  always_comb begin
    rx_ready_o = rx_ready_int;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    busy_o     = (state_q != S_OPCODE);
    err_o      = 1'b0;
    case (state_q)
      S_DECIDE:   err_o = pkt_invalid;
      S_ECHO: begin
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      S_TRANSMIT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'(acc_q >> {tx_idx_q, 3'b000});
      end
      default: ;
    endcase
    if (reset_i) begin
      rx_ready_o = 1'b0;
      tx_valid_o = 1'b0;
      tx_data_o  = '0;
      busy_o     = 1'b0;
      err_o      = 1'b0;
    end
  end

  // Datapath: header capture, payload counting, operand accumulation, TX index
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      opcode_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      acc_q      <= '0;
      byte_idx_q <= '0;
      first_q    <= 1'b1;
      tx_idx_q   <= '0;
    end else begin
      case (state_q)
        S_OPCODE: if (rx_fire) opcode_q <= rx_data_i;
        S_LENLO:  if (rx_fire) len_q[7:0] <= rx_data_i;
        S_LENHI:  if (rx_fire) len_q[LEN_W-1:8] <= rx_data_i;
        S_DECIDE: begin
          cnt_q      <= p_len;
          shreg_q    <= '0;
          byte_idx_q <= '0;
          first_q    <= 1'b1;
          tx_idx_q   <= '0;
        end
        S_OPERAND: if (rx_fire) begin
          cnt_q <= cnt_q - ONE_L;
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_q <= '0;
            first_q    <= 1'b0;
            shreg_q    <= '0;
            acc_q      <= first_q ? operand_next : combined;
          end else begin
            byte_idx_q <= byte_idx_q + 4'd1;
            shreg_q    <= operand_next;
          end
        end
        S_TRANSMIT: if (tx_ready_i) begin
          tx_idx_q <= (tx_idx_q == LAST_IDX) ? '0 : tx_idx_q + 4'd1;
        end
        S_ECHO, S_DRAIN: if (rx_fire) cnt_q <= cnt_q - ONE_L;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_packet_fsm.sv
// Directed testbench for alu_packet_fsm (DATA_W=32). Expectations for opcode
// 0x30 follow the ALU_MUL_EN macro.
module tb_alu_packet_fsm;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b1;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int passed = 0;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pk[$];
  int         err_cnt = 0;
  bit         toggle_mode = 1'b0;
  logic       stall_d = 1'b0;
  logic [7:0] stall_data = '0;

  alu_packet_fsm #(.DATA_W(32), .LEN_W(16)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  // TX sink: always ready, or toggling every cycle for backpressure tests
  always @(posedge clk_i) begin
    #1;
    tx_ready_i = toggle_mode ? ~tx_ready_i : 1'b1;
  end

  // Monitor: collect TX handshakes, count err pulses, check held data under stall
  always @(negedge clk_i) begin
    if (stall_d && !reset_i) begin
      checks++;
      if (!tx_valid_o || tx_data_o !== stall_data)
        $display("FAIL tx_hold got valid=%b data=%h exp valid=1 data=%h", tx_valid_o, tx_data_o, stall_data);
      else passed++;
    end
    stall_d    = tx_valid_o && !tx_ready_i && !reset_i;
    stall_data = tx_data_o;
    if (tx_valid_o && tx_ready_i && !reset_i) q.push_back(tx_data_o);
    if (err_o) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Called at posedge+1; returns at posedge+1 after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input bit echo_chk);
    bit ok = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk_i);
      if (echo_chk) begin
        checks++;
        if (rx_ready_o !== tx_ready_i)
          $display("FAIL echo_ready got %b exp %b", rx_ready_o, tx_ready_i);
        else passed++;
      end
      ok = rx_ready_o;
    end
    if (!ok) begin
      checks++;
      $display("FAIL rx_accept_timeout byte %h got ready=0 exp ready=1", b);
    end
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pk.size(); i++) send_byte(pk[i], 1'b0);
  endtask

  task automatic wait_idle();
    repeat (30) @(posedge clk_i);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    err_cnt = 0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (rx_ready_o !== 1'b0) $display("FAIL rst_rx_ready got %b exp 0", rx_ready_o); else passed++;
    checks++; if (tx_valid_o !== 1'b0) $display("FAIL rst_tx_valid got %b exp 0", tx_valid_o); else passed++;
    checks++; if (tx_data_o !== 8'h00) $display("FAIL rst_tx_data got %h exp 00", tx_data_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_o); else passed++;
    checks++; if (err_o !== 1'b0) $display("FAIL rst_err got %b exp 0", err_o); else passed++;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rx_ready_o !== 1'b1) $display("FAIL post_rst_rx_ready got %b exp 1", rx_ready_o); else passed++;
    checks++; if (busy_o !== 1'b0) $display("FAIL post_rst_busy got %b exp 0", busy_o); else passed++;
    @(posedge clk_i); #1;
    clear_mon();
  endtask

  task automatic test_add();
    clear_mon();
    pk = '{8'h20, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_pkt();
    @(negedge clk_i);
    checks++; if (tx_valid_o !== 1'b1) $display("FAIL add_latency got %b exp 1", tx_valid_o); else passed++;
    wait_idle();
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    checks++; if (q.size() != exp_q.size()) $display("FAIL add_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL add_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    checks++; if (err_cnt != 0) $display("FAIL add_err got %0d exp 0", err_cnt); else passed++;
  endtask

  task automatic test_echo();
    clear_mon();
    toggle_mode = 1'b1;
    pk = '{8'h10, 8'h00, 8'h07, 8'h00};
    send_pkt();
    @(posedge clk_i); #1;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    wait_idle();
    toggle_mode = 1'b0;
    exp_q = '{8'h41, 8'h42, 8'h43};
    checks++; if (q.size() != exp_q.size()) $display("FAIL echo_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL echo_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    checks++; if (err_cnt != 0) $display("FAIL echo_err got %0d exp 0", err_cnt); else passed++;
    // Empty echo: no output and no error
    clear_mon();
    pk = '{8'h10, 8'h00, 8'h04, 8'h00};
    send_pkt();
    wait_idle();
    checks++; if (q.size() != 0 || err_cnt != 0) $display("FAIL echo_empty got tx=%0d err=%0d exp tx=0 err=0", q.size(), err_cnt); else passed++;
  endtask

  task automatic test_bad_opcode();
    clear_mon();
    pk = '{8'h55, 8'h00, 8'h06};
    send_pkt();
    send_byte(8'h00, 1'b0);
    @(negedge clk_i);
    checks++; if (err_o !== 1'b1) $display("FAIL bad_err_decide got %b exp 1", err_o); else passed++;
    checks++; if (rx_ready_o !== 1'b0) $display("FAIL bad_ready_decide got %b exp 0", rx_ready_o); else passed++;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++; if (err_o !== 1'b0) $display("FAIL bad_err_after got %b exp 0", err_o); else passed++;
    @(posedge clk_i); #1;
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    pk = '{8'h40, 8'h00, 8'h08, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_idle();
    checks++; if (err_cnt != 1) $display("FAIL bad_err_count got %0d exp 1", err_cnt); else passed++;
    exp_q = '{8'h0F, 8'h00, 8'h00, 8'h00};
    checks++; if (q.size() != exp_q.size()) $display("FAIL bad_next_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL bad_next_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_mul();
    clear_mon();
    pk = '{8'h30, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
           8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_idle();
`ifdef ALU_MUL_EN
    exp_q = '{8'h0F, 8'h00, 8'h00, 8'h00};
    checks++; if (err_cnt != 0) $display("FAIL mul_err got %0d exp 0", err_cnt); else passed++;
`else
    exp_q.delete();
    checks++; if (err_cnt != 1) $display("FAIL mul_err got %0d exp 1", err_cnt); else passed++;
`endif
    checks++; if (q.size() != exp_q.size()) $display("FAIL mul_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL mul_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_len_err();
    clear_mon();
    pk = '{8'h40, 8'h00, 8'h09, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_pkt();
    wait_idle();
    checks++; if (err_cnt != 1 || q.size() != 0) $display("FAIL len_mod got err=%0d tx=%0d exp err=1 tx=0", err_cnt, q.size()); else passed++;
    clear_mon();
    pk = '{8'h40, 8'h00, 8'h02, 8'h00};
    send_pkt();
    @(negedge clk_i);
    checks++; if (err_o !== 1'b1) $display("FAIL len_short_err got %b exp 1", err_o); else passed++;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || rx_ready_o !== 1'b1) $display("FAIL len_short_idle got busy=%b ready=%b exp busy=0 ready=1", busy_o, rx_ready_o); else passed++;
    @(posedge clk_i); #1;
    pk = '{8'h20, 8'h00, 8'h08, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_idle();
    exp_q = '{8'h07, 8'h00, 8'h00, 8'h00};
    checks++; if (err_cnt != 1) $display("FAIL len_short_err_count got %0d exp 1", err_cnt); else passed++;
    checks++; if (q.size() != exp_q.size()) $display("FAIL len_next_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL len_next_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    toggle_mode = 1'b1;
    pk = '{8'h40, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00,
           8'h0F, 8'h0F, 8'h0F, 8'h0F,
           8'h20, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'h11, 8'h11, 8'h11, 8'h11};
    send_pkt();
    wait_idle();
    toggle_mode = 1'b0;
    exp_q = '{8'hF0, 8'h0F, 8'hF0, 8'h0F, 8'h89, 8'h67, 8'h45, 8'h23};
    checks++; if (q.size() != exp_q.size()) $display("FAIL b2b_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
    checks++; if (err_cnt != 0) $display("FAIL b2b_err got %0d exp 0", err_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pk = '{8'h20, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    @(negedge clk_i);
    checks++; if (rx_ready_o !== 1'b0 || tx_valid_o !== 1'b0 || tx_data_o !== 8'h00 || busy_o !== 1'b0)
      $display("FAIL midrst_outputs got ready=%b valid=%b data=%h busy=%b exp 0 0 00 0", rx_ready_o, tx_valid_o, tx_data_o, busy_o);
    else passed++;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    checks++; if (q.size() != 1 || q[0] !== 8'h03) $display("FAIL midrst_partial got count=%0d exp count=1 byte 03", q.size()); else passed++;
    clear_mon();
    pk = '{8'h40, 8'h00, 8'h08, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00};
    send_pkt();
    wait_idle();
    exp_q = '{8'h5A, 8'h00, 8'h00, 8'h00};
    checks++; if (q.size() != exp_q.size()) $display("FAIL midrst_next_count got %0d exp %0d", q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= q.size() || q[i] !== exp_q[i]) $display("FAIL midrst_next_byte%0d got %h exp %h", i, (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_echo();
    test_bad_opcode();
    test_mul();
    test_len_err();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
